mdu_execute: RTL

- Iterative multiply/divide unit in the execute stage, owning the HI/LO architectural registers.
- Consumes operands and an op strobe from the decode→execute pipeline register.
- Runs MULT/MULTU/DIV/DIVU over multiple cycles and updates HI/LO on completion.
- Drives a stall back toward decode/execute while busy, so the pipeline register ahead of it holds.

---
 rtl/mdu_execute_if.sv | 33 +++
 rtl/mdu_execute.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mdu_execute_if.sv
// Execute-stage hookup of the multiply/divide unit.
//   start_E   : op request valid this cycle
//   op_E      : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a_E, b_E  : rs / rt operands
//   rd_hilo_E : MFHI/MFLO currently in execute
//   hi, lo    : architectural HI/LO registers
//   busy      : multi-cycle op in flight
//   done      : one-cycle pulse when HI/LO were written by MULT/DIV
//   stall     : hold the upstream pipeline register
interface mdu_execute_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_E;
    logic [2:0]       op_E;
    logic [WIDTH-1:0] a_E;
    logic [WIDTH-1:0] b_E;
    logic             rd_hilo_E;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start_E, op_E, a_E, b_E, rd_hilo_E,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start_E, op_E, a_E, b_E, rd_hilo_E,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mdu_execute.sv
// Iterative multiply/divide unit owning HI/LO.
//   clk, reset : pipeline clock, asynchronous active-high reset
//   bus        : slave side of mdu_execute_if (request in, HI/LO/status out)
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, both on operand
// magnitudes for WIDTH cycles; sign correction is applied in the FIX cycle.
module mdu_execute #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    mdu_execute_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned DW    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    acc;      // product, or {remainder, quotient/dividend}
    logic [DW-1:0]    mcand;    // shifted multiplicand
    logic [WIDTH-1:0] opb;      // multiplier or divisor magnitude
    logic [WIDTH-1:0] a_raw;    // dividend as latched, for divide-by-zero HI
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             is_div, neg_q, neg_r, div_zero, done_q;

    // Operand magnitudes for the incoming request
    logic             sgn_op, start_md;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        sgn_op   = ~bus.op_E[0];
        start_md = bus.start_E & ~bus.op_E[2];
        mag_a    = (sgn_op && bus.a_E[WIDTH-1]) ? WIDTH'(-bus.a_E) : bus.a_E;
        mag_b    = (sgn_op && bus.b_E[WIDTH-1]) ? WIDTH'(-bus.b_E) : bus.b_E;
    end

    // One iteration of each algorithm; the shifted remainder needs WIDTH+1 bits
    logic [WIDTH:0] rem_sh, rem_diff;
    logic [DW-1:0]  acc_mul_step, acc_div_step;

    always_comb begin
        rem_sh       = acc[DW-1:WIDTH-1];
        rem_diff     = rem_sh - {1'b0, opb};
        acc_div_step = (rem_sh >= {1'b0, opb}) ? {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                               : {acc[DW-2:0], 1'b0};
        acc_mul_step = acc + (opb[0] ? mcand : DW'(0));
    end

    // Final sign correction and divide-by-zero result
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

    always_comb begin
        prod = neg_q ? DW'(-acc) : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[DW-1:WIDTH];
        if (!is_div) begin
            res_hi = prod[DW-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = neg_r ? WIDTH'(-rem) : rem;
            res_lo = neg_q ? WIDTH'(-quo) : quo;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_md) state_next = CALC;
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, HI/LO and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            opb      <= '0;
            a_raw    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_md) begin
                        cnt      <= '0;
                        is_div   <= bus.op_E[1];
                        a_raw    <= bus.a_E;
                        opb      <= mag_b;
                        neg_q    <= sgn_op & (bus.a_E[WIDTH-1] ^ bus.b_E[WIDTH-1]);
                        neg_r    <= sgn_op & bus.a_E[WIDTH-1];
                        div_zero <= (bus.b_E == '0);
                        if (bus.op_E[1]) begin
                            acc   <= {WIDTH'(0), mag_a};
                            mcand <= '0;
                        end else begin
                            acc   <= '0;
                            mcand <= {WIDTH'(0), mag_a};
                        end
                    end else if (bus.start_E && bus.op_E == 3'd4) begin
                        hi_q <= bus.a_E;
                    end else if (bus.start_E && bus.op_E == 3'd5) begin
                        lo_q <= bus.a_E;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        acc <= acc_div_step;
                    end else begin
                        acc   <= acc_mul_step;
                        mcand <= {mcand[DW-2:0], 1'b0};
                        opb   <= {1'b0, opb[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state != IDLE);
    assign bus.stall = bus.busy & (bus.start_E | bus.rd_hilo_E);
endmodule
